pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing block; consumes the 2-bit next-instruction select produced by the PC decode logic.
- Holds the architectural PC and selects sequential, jump-immediate, jump-register or taken-branch targets.
- Drives the instruction-memory address and a wrong-path flush to the IF/ID pipeline registers.
- Sits between control decode and instruction memory.

Parameters:
- ADDR_W, 16, PC / instruction-memory word-address width.
- OFF_W, 12, signed branch offset width in words.
- RESET_PC, 0, PC value loaded by reset.
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect (1..7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- sel_valid  input  1  next_instr_sel is meaningful this cycle.
- next_instr_sel  input  2  00 sequential, 01 jump immediate, 10 jump register, 11 branch taken.
- resolve_pc  input  ADDR_W  PC of the resolving control instruction.
- imm_target  input  ADDR_W  absolute jump target.
- reg_target  input  32  register-file jump target; low ADDR_W bits used.
- branch_offset  input  OFF_W  signed word offset, relative to resolve_pc.
- stall  input  1  hazard stall from pipeline; holds PC.
- pc  output  ADDR_W  current fetch address.
- fetch_valid  output  1  instruction at pc is to be latched into IF/ID.
- flush  output  1  squash IF/ID and ID/EX contents.
- redirect_count  output  16  taken-redirect counter (see Optional Feature).

Behaviour:
- Reset (rst high at edge): state=BOOT, pc=RESET_PC, fetch_valid=0, flush=0, flush counter=0, redirect_count=0. Reset wins over every other input in any state, including mid-flush.
- States: BOOT, RUN, FLUSH.
- BOOT:
  - Lasts exactly one cycle; fetch_valid=0; pc holds RESET_PC.
  - Goes to RUN; sel_valid and stall are ignored.
- RUN:
  - fetch_valid = !stall (combinational).
  - A redirect is sel_valid=1 with next_instr_sel != 00. On a redirect at edge N:
    - 01: pc <= imm_target.
    - 10: pc <= reg_target[ADDR_W-1:0].
    - 11: pc <= resolve_pc + sign_extend(branch_offset).
  - After a redirect: flush <= 1, counter <= FLUSH_CYCLES-1, state <= FLUSH.
  - A redirect has priority over stall: a redirect is taken even while stall=1.
  - No redirect and stall=1: pc holds.
  - No redirect and stall=0: pc <= pc + 1.
  - next_instr_sel=00 with sel_valid=1 is treated as sequential.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES consecutive cycles (N+1 .. N+FLUSH_CYCLES).
  - pc advances from the target per the stall rule; fetch_valid = !stall.
  - sel_valid is ignored, because the sources are wrong-path instructions.
  - Counter decrements each cycle regardless of stall. Counter at 0: flush <= 0, state <= RUN.
- Arithmetic:
  - All PC math is modulo 2^ADDR_W; pc+1 wraps from all-ones to 0.
  - Branch target wraps in both directions; no overflow flag.
- pc, flush and state are registered. fetch_valid is the only combinational output.
- Latency: redirect select to new pc = 1 cycle. No bubble is inserted beyond the flush squash.

Optional Feature:
- Macro: PC_REDIRECT_COUNT_EN.
- Defined:
  - redirect_count increments by 1 on each accepted redirect. A redirect is accepted when the RUN state sees sel_valid=1 with next_instr_sel != 00.
  - The counter saturates at 16'hFFFF and clears only on rst.
- Undefined:
  - No counter register is built; redirect_count is tied to 0.
  - The port still exists, so the interface does not change.

Test Plan:
- Reset release, no stall, sel_valid=0, RESET_PC=0 -> pc=0 for 2 cycles (reset + BOOT), fetch_valid=0 in BOOT, then pc=1,2,3 on successive cycles.
- RUN at pc=5, sel_valid=1, sel=11, resolve_pc=3, branch_offset=-2 (12'hFFE) -> next pc=1, flush=1 for exactly 2 cycles. A sel_valid=1/sel=01 pulse during flush is ignored, and pc continues 2,3.
- sel=01 imm_target=16'h0040 with stall=1 -> pc=16'h0040 next cycle (redirect beats stall). With stall held afterwards, pc holds at 16'h0040 and fetch_valid=0.
- sel=10, reg_target=32'h1234_FFFF -> pc=16'hFFFF. Next sequential cycle gives pc=16'h0000 (wrap).
- rst asserted in the 1st flush cycle -> next cycle pc=RESET_PC, flush=0, state BOOT, redirect_count=0.
- With PC_REDIRECT_COUNT_EN: 3 redirects spaced 4 cycles apart -> redirect_count=3. A redirect attempted inside FLUSH is not counted. Without the macro, redirect_count stays 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   This block holds the architectural program counter and sequences fetch.
//   It uses the 2-bit next-instruction select from PC decode to choose one of
//   four next PCs:
//     - sequential (pc+1)
//     - jump-immediate
//     - jump-register
//     - taken branch (resolve_pc + sign-extended offset)
//   When a redirect is taken, flush is raised for FLUSH_CYCLES cycles. This
//   squashes the wrong-path instructions already held in IF/ID and ID/EX.
//   All PC arithmetic wraps modulo 2^ADDR_W.
//
// Parameters:
//   ADDR_W        PC / instruction-memory word-address width
//   OFF_W         signed branch offset width (words), OFF_W <= ADDR_W
//   RESET_PC      PC loaded by reset
//   FLUSH_CYCLES  number of cycles flush stays high after a redirect (1..7)
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   sel_valid       next_instr_sel is meaningful this cycle
//   next_instr_sel  00 seq, 01 jump imm, 10 jump reg, 11 branch taken
//   resolve_pc      PC of the resolving control instruction
//   imm_target      absolute jump target
//   reg_target      register-file jump target (low ADDR_W bits used)
//   branch_offset   signed word offset relative to resolve_pc
//   stall           hazard stall, holds PC
//   pc              current fetch address (registered)
//   fetch_valid     instruction at pc is to be latched (combinational)
//   flush           squash IF/ID and ID/EX (registered)
//   redirect_count  saturating count of accepted redirects
//
// Optional feature:
//   Define PC_REDIRECT_COUNT_EN to build the redirect counter. When the macro
//   is not defined, redirect_count is tied to zero.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int              ADDR_W       = 16,
    parameter int              OFF_W        = 12,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_valid,
    input  logic [1:0]        next_instr_sel,
    input  logic [ADDR_W-1:0] resolve_pc,
    input  logic [ADDR_W-1:0] imm_target,
    input  logic [31:0]       reg_target,
    input  logic [OFF_W-1:0]  branch_offset,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              flush,
    output logic [15:0]       redirect_count
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                flush_q, flush_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                redirect;

    logic signed [OFF_W-1:0]  off_s;
    logic signed [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0]        pc_inc;
    logic [ADDR_W-1:0]        br_target;
    logic [ADDR_W-1:0]        redirect_target;

    // Only the low ADDR_W bits of the register target are used.
    generate
        if (ADDR_W < 32) begin : g_unused_reg
            logic unused_reg_hi;
            assign unused_reg_hi = ^reg_target[31:ADDR_W];
        end
    endgenerate

    // Sign-extend the offset through a signed size cast. The wrapping add
    // then covers both the forward and the backward branch direction.
    assign off_s     = branch_offset;
    assign off_ext   = ADDR_W'(off_s);
    assign br_target = resolve_pc + $unsigned(off_ext);
    assign pc_inc    = pc_q + ADDR_W'(1);

    always_comb begin
        redirect_target = pc_inc;
        case (next_instr_sel)
            2'b01:   redirect_target = imm_target;
            2'b10:   redirect_target = reg_target[ADDR_W-1:0];
            2'b11:   redirect_target = br_target;
            default: redirect_target = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = flush_q;
        cnt_d    = cnt_q;
        redirect = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // A redirect takes priority over stall.
                if (sel_valid && (next_instr_sel != 2'b00)) begin
                    redirect = 1'b1;
                    pc_d     = redirect_target;
                    flush_d  = 1'b1;
                    cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
                    state_d  = ST_FLUSH;
                end else if (!stall) begin
                    pc_d = pc_inc;
                end
            end

            ST_FLUSH: begin
                // Selects in this state come from wrong-path instructions,
                // so they are ignored. The flush timer counts down even
                // while the pipeline is stalled.
                if (!stall) begin
                    pc_d = pc_inc;
                end
                if (cnt_q == '0) begin
                    flush_d = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign fetch_valid = (state_q != ST_BOOT) && !stall;

`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0] rcnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q <= '0;
        end else if (redirect) begin
            rcnt_q <= sat_inc16(rcnt_q);
        end
    end

    assign redirect_count = rcnt_q;
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
    assign redirect_count  = 16'd0;
`endif

endmodule
